mem_port_arbiter: RTL and testbench

Shares the CPU's single external memory/MIO port between the IF stage (instruction fetch) and the MEM stage (load/store) of the 5-stage pipeline. Grants one requester at a time, drives the bus with registered address/data/control, waits for `bus_ready` with a watchdog timeout, and returns a one-cycle acknowledge plus registered read data. It also produces the stall signals the pipeline uses to freeze PC/IF_ID and the downstream registers while a port is waiting.

---
 rtl/mem_arb_pkg.sv | 24 ++
 rtl/arb_watchdog.sv | 30 +++
 rtl/mem_port_arbiter.sv | 168 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared encodings for the memory port arbiter
package mem_arb_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_BUSY = 2'd1,
      ARB_DONE = 2'd2
   } arb_state_e;

   // grant identifiers, also the encoding of the last-grant register
   localparam logic GNT_IF = 1'b0;
   localparam logic GNT_D  = 1'b1;

   // read data returned by a transaction that hit the watchdog
   localparam int unsigned ERR_RDATA = 0;

   // dm_ctrl access-width codes shared with the data memory
   localparam logic [2:0] DM_WORD          = 3'd0;
   localparam logic [2:0] DM_HALFWORD      = 3'd1;
   localparam logic [2:0] DM_HALFWORD_UNS  = 3'd2;
   localparam logic [2:0] DM_BYTE          = 3'd3;
   localparam logic [2:0] DM_BYTE_UNS      = 3'd4;

endpackage

// File: rtl/arb_watchdog.sv
// rtl/arb_watchdog.sv - BUSY-cycle counter that flags a stuck memory transaction
module arb_watchdog #(
   parameter int TIMEOUT = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic i_clr,
   input  logic i_en,
   output logic o_expired
);

   localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   logic [CW-1:0] r_cnt;

   // count enabled cycles, holding at the limit so a late clear still sees it expired
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_en && !o_expired) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   // TIMEOUT of zero means the watchdog never fires
   assign o_expired = (TIMEOUT != 0) && (r_cnt == CW'(TIMEOUT));

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - IF/MEM sharing of one memory port; MEM_ARB_RR_EN selects round-robin priority
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int TIMEOUT = 255
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          if_req,
   input  logic [AW-1:0] if_addr,
   output logic [DW-1:0] if_rdata,
   output logic          if_ack,
   input  logic          d_req,
   input  logic          d_we,
   input  logic [2:0]    d_ctrl,
   input  logic [AW-1:0] d_addr,
   input  logic [DW-1:0] d_wdata,
   output logic [DW-1:0] d_rdata,
   output logic          d_ack,
   output logic          bus_req,
   output logic          bus_we,
   output logic [2:0]    bus_ctrl,
   output logic [AW-1:0] bus_addr,
   output logic [DW-1:0] bus_wdata,
   input  logic [DW-1:0] bus_rdata,
   input  logic          bus_ready,
   output logic          stall_if,
   output logic          stall_mem,
   output logic          bus_err
);

   arb_state_e    r_state;
   logic          r_gnt;
   logic          r_bus_req;
   logic          r_bus_we;
   logic [2:0]    r_bus_ctrl;
   logic [AW-1:0] r_bus_addr;
   logic [DW-1:0] r_bus_wdata;
   logic          r_if_ack;
   logic          r_d_ack;
   logic [DW-1:0] r_if_rdata;
   logic [DW-1:0] r_d_rdata;
   logic          r_bus_err;

   logic          w_any_req;
   logic          w_gnt;
   logic          w_expired;
   logic          w_finish;
   logic [DW-1:0] w_rdata;

   assign w_any_req = if_req | d_req;

`ifdef MEM_ARB_RR_EN
   logic r_last_gnt;

   // on contention hand the port to whoever did not get it last time
   always_comb begin
      w_gnt = GNT_IF;
      if (if_req && d_req) begin
         w_gnt = ~r_last_gnt;
      end else if (d_req) begin
         w_gnt = GNT_D;
      end
   end

   // remember the most recent grant
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_last_gnt <= GNT_IF;
      end else if (r_state == ARB_IDLE && w_any_req) begin
         r_last_gnt <= w_gnt;
      end
   end
`else
   // the MEM stage holds the older instruction, so it always wins
   assign w_gnt = d_req ? GNT_D : GNT_IF;
`endif

   arb_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
      .clk       (clk),
      .rst       (rst),
      .i_clr     (r_state == ARB_IDLE),
      .i_en      (r_state == ARB_BUSY),
      .o_expired (w_expired)
   );

   // a ready response takes precedence over a watchdog expiring in the same cycle
   assign w_finish = bus_ready | w_expired;
   assign w_rdata  = bus_ready ? bus_rdata : DW'(ERR_RDATA);

   // arbitration FSM with registered bus, ack, rdata and error outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= ARB_IDLE;
         r_gnt       <= GNT_IF;
         r_bus_req   <= 1'b0;
         r_bus_we    <= 1'b0;
         r_bus_ctrl  <= DM_WORD;
         r_bus_addr  <= '0;
         r_bus_wdata <= '0;
         r_if_ack    <= 1'b0;
         r_d_ack     <= 1'b0;
         r_if_rdata  <= '0;
         r_d_rdata   <= '0;
         r_bus_err   <= 1'b0;
      end else begin
         case (r_state)
            ARB_IDLE: begin
               if (w_any_req) begin
                  r_gnt     <= w_gnt;
                  r_bus_req <= 1'b1;
                  r_state   <= ARB_BUSY;
                  if (w_gnt == GNT_D) begin
                     r_bus_addr  <= d_addr;
                     r_bus_we    <= d_we;
                     r_bus_ctrl  <= d_ctrl;
                     r_bus_wdata <= d_wdata;
                  end else begin
                     r_bus_addr  <= if_addr;
                     r_bus_we    <= 1'b0;
                     r_bus_ctrl  <= DM_WORD;
                     r_bus_wdata <= '0;
                  end
               end
            end
            ARB_BUSY: begin
               if (w_finish) begin
                  r_bus_req <= 1'b0;
                  r_bus_err <= ~bus_ready;
                  r_state   <= ARB_DONE;
                  if (r_gnt == GNT_D) begin
                     r_d_rdata <= w_rdata;
                     r_d_ack   <= 1'b1;
                  end else begin
                     r_if_rdata <= w_rdata;
                     r_if_ack   <= 1'b1;
                  end
               end
            end
            ARB_DONE: begin
               r_if_ack  <= 1'b0;
               r_d_ack   <= 1'b0;
               r_bus_err <= 1'b0;
               r_state   <= ARB_IDLE;
            end
            default: begin
               r_state <= ARB_IDLE;
            end
         endcase
      end
   end

   assign bus_req   = r_bus_req;
   assign bus_we    = r_bus_we;
   assign bus_ctrl  = r_bus_ctrl;
   assign bus_addr  = r_bus_addr;
   assign bus_wdata = r_bus_wdata;
   assign if_ack    = r_if_ack;
   assign d_ack     = r_d_ack;
   assign if_rdata  = r_if_rdata;
   assign d_rdata   = r_d_rdata;
   assign bus_err   = r_bus_err;
   assign stall_if  = if_req & ~r_if_ack;
   assign stall_mem = d_req & ~r_d_ack;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - randomized transaction-level check of mem_port_arbiter
module tb_mem_port_arbiter;

   localparam int T = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        if_req = 1'b0;
   logic [31:0] if_addr = '0;
   logic [31:0] if_rdata;
   logic        if_ack;
   logic        d_req = 1'b0;
   logic        d_we = 1'b0;
   logic [2:0]  d_ctrl = '0;
   logic [31:0] d_addr = '0;
   logic [31:0] d_wdata = '0;
   logic [31:0] d_rdata;
   logic        d_ack;
   logic        bus_req;
   logic        bus_we;
   logic [2:0]  bus_ctrl;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic [31:0] bus_rdata = '0;
   logic        bus_ready = 1'b0;
   logic        stall_if;
   logic        stall_mem;
   logic        bus_err;

   mem_port_arbiter #(.AW(32), .DW(32), .TIMEOUT(T)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
      .d_req(d_req), .d_we(d_we), .d_ctrl(d_ctrl), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_ack(d_ack),
      .bus_req(bus_req), .bus_we(bus_we), .bus_ctrl(bus_ctrl), .bus_addr(bus_addr),
      .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ready(bus_ready),
      .stall_if(stall_if), .stall_mem(stall_mem), .bus_err(bus_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk = 0;
   int n_fail = 0;

   task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // memory behaviour per port: wait cycles before ready, and read data returned
   int          wt[2];
   logic [31:0] mem_data[2];
   logic [31:0] exp_rdata[2];
   int          m_last;

   // predicted transactions of the current scenario
   int t_port[2];
   int t_start[2];
   int t_ack[2];
   bit t_err[2];
   int nt;

   function automatic int lat(input int w);
      return 2 + ((w < T) ? w : T);
   endfunction

   task automatic add_txn(input int p, input int s);
      t_port[nt]  = p;
      t_start[nt] = s;
      t_err[nt]   = (wt[p] > T);
      t_ack[nt]   = s + lat(wt[p]);
      m_last      = p;
      nt++;
   endtask

   task automatic run_scn(input bit do_if, input bit do_d, input bit hold);
      int s, last, p1, busy, ak;
      int last_ack[2];
      bit [1:0] e_ack;
      bit e_err;
      @(negedge clk);
      s = cyc;
      if_req = do_if;
      d_req  = do_d;
      nt = 0;
      if (do_if && do_d) begin
`ifdef MEM_ARB_RR_EN
         p1 = (m_last == 0) ? 1 : 0;
`else
         p1 = 1;
`endif
         add_txn(p1, s);
         add_txn(1 - p1, t_ack[0] + 1);
      end else begin
         p1 = do_d ? 1 : 0;
         add_txn(p1, s);
         if (hold) add_txn(p1, t_ack[0] + 1);
      end
      last_ack[0] = -1;
      last_ack[1] = -1;
      for (int k = 0; k < nt; k++) last_ack[t_port[k]] = t_ack[k];
      last = t_ack[nt-1];
      for (int c = s; c <= last + 2; c++) begin
         e_ack = 2'b00;
         e_err = 1'b0;
         busy  = -1;
         ak    = -1;
         for (int k = 0; k < nt; k++) begin
            if (t_ack[k] == c) begin
               e_ack[t_port[k]] = 1'b1;
               e_err = t_err[k];
               ak = k;
            end
            if (c > t_start[k] && c < t_ack[k]) busy = k;
         end
         if (busy >= 0) begin
            bus_ready = ((c - t_start[busy] - 1) == wt[t_port[busy]]);
            bus_rdata = mem_data[t_port[busy]];
         end else begin
            bus_ready = 1'($urandom_range(0, 1));
            bus_rdata = $urandom;
         end
         #1;
         check_eq("if_ack", if_ack, e_ack[0]);
         check_eq("d_ack", d_ack, e_ack[1]);
         check_eq("bus_req", bus_req, busy >= 0);
         check_eq("bus_err", bus_err, e_err);
         check_eq("stall_if", stall_if, do_if && c < last_ack[0] && !e_ack[0]);
         check_eq("stall_mem", stall_mem, do_d && c < last_ack[1] && !e_ack[1]);
         if (busy >= 0) begin
            if (t_port[busy] == 1)
               check_eq("bus_d_fields", {bus_addr, bus_we, bus_ctrl, bus_wdata},
                        {d_addr, d_we, d_ctrl, d_wdata});
            else
               check_eq("bus_if_fields", {bus_addr, bus_we}, {if_addr, 1'b0});
         end
         if (ak >= 0) begin
            exp_rdata[t_port[ak]] = t_err[ak] ? 32'h0 : mem_data[t_port[ak]];
            if (t_port[ak] == 1) check_eq("d_rdata", d_rdata, exp_rdata[1]);
            else                 check_eq("if_rdata", if_rdata, exp_rdata[0]);
         end
         if (c == last_ack[0]) if_req = 1'b0;
         if (c == last_ack[1]) d_req = 1'b0;
         @(negedge clk);
      end
      #1;
      check_eq("if_rdata_hold", if_rdata, exp_rdata[0]);
      check_eq("d_rdata_hold", d_rdata, exp_rdata[1]);
   endtask

   task automatic reset_mid_busy();
      @(negedge clk);
      d_addr = 32'h0000_0300;
      d_we   = 1'b0;
      d_ctrl = 3'd3;
      wt[1]  = 6;
      bus_ready = 1'b0;
      d_req  = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      check_eq("rst_pre_bus_req", bus_req, 1'b1);
      rst = 1'b0;
      #1;
      check_eq("rst_bus_req", bus_req, 1'b0);
      check_eq("rst_acks", {if_ack, d_ack, bus_err}, 3'b000);
      check_eq("rst_rdata", {if_rdata, d_rdata}, 64'h0);
      d_req = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      check_eq("rst_hold_acks", {if_ack, d_ack, bus_req}, 3'b000);
      rst = 1'b1;
      m_last = 0;
      exp_rdata[0] = '0;
      exp_rdata[1] = '0;
      repeat (2) @(negedge clk);
      #1;
      check_eq("post_rst_idle", {if_ack, d_ack, bus_req, bus_err}, 4'b0000);
   endtask

   initial begin
      bit [1:0] sel;
      wt[0] = 0; wt[1] = 0;
      mem_data[0] = '0; mem_data[1] = '0;
      exp_rdata[0] = '0; exp_rdata[1] = '0;
      m_last = 0;
      repeat (3) @(negedge clk);
      #1;
      check_eq("reset_bus", {bus_req, bus_we, bus_ctrl, bus_addr, bus_wdata}, '0);
      check_eq("reset_acks", {if_ack, d_ack, bus_err}, 3'b000);
      check_eq("reset_rdata", {if_rdata, d_rdata}, 64'h0);
      rst = 1'b1;
      @(negedge clk);

      // lone fetch, ready in the first BUSY cycle
      if_addr = 32'h0000_0010; mem_data[0] = 32'h0000_0093; wt[0] = 0;
      run_scn(1'b1, 1'b0, 1'b0);
      // store with three wait cycles
      d_we = 1'b1; d_addr = 32'h0000_0100; d_wdata = 32'hCAFE_F00D; d_ctrl = 3'd0;
      mem_data[1] = 32'h1234_5678; wt[1] = 3;
      run_scn(1'b0, 1'b1, 1'b0);
      // simultaneous requests
      if_addr = 32'h0000_0014; d_we = 1'b0; d_addr = 32'h0000_0200; wt[0] = 0; wt[1] = 0;
      mem_data[0] = 32'h0000_0013; mem_data[1] = 32'hDEAD_BEEF;
      run_scn(1'b1, 1'b1, 1'b0);
      // watchdog timeouts on each port
      wt[0] = T + 1;
      run_scn(1'b1, 1'b0, 1'b0);
      wt[1] = T + 3;
      run_scn(1'b0, 1'b1, 1'b0);
      // ready on the last permitted cycle is a normal completion
      wt[1] = T;
      run_scn(1'b0, 1'b1, 1'b0);
      // fetch request held across its ack
      wt[0] = 1; mem_data[0] = 32'h0040_0513;
      run_scn(1'b1, 1'b0, 1'b1);
      // reset during a load, then a clean fetch
      reset_mid_busy();
      wt[0] = 0; if_addr = 32'h0000_0020; mem_data[0] = 32'h00A0_0093;
      run_scn(1'b1, 1'b0, 1'b0);

      for (int i = 0; i < 40; i++) begin
         sel = 2'($urandom_range(1, 3));
         if_addr = $urandom & 32'hFFFF_FFFC;
         d_addr = $urandom;
         d_we = 1'($urandom_range(0, 1));
         d_ctrl = 3'($urandom_range(0, 4));
         d_wdata = $urandom;
         mem_data[0] = $urandom;
         mem_data[1] = $urandom;
         wt[0] = $urandom_range(0, 6);
         wt[1] = $urandom_range(0, 6);
         run_scn(sel[0], sel[1], sel == 2'b01 && $urandom_range(0, 3) == 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
